sar_adc_multichannel: RTL and testbench
=======================================

# sar_adc_multichannel

Parametrised multi-channel successive-approximation ADC controller with an ideal digital comparator. Sequences conversions over a latched channel mask, generates its own bit-cycle tick from the system clock, and reports each result with a one-cycle `eoc` strobe tagged by channel. Generalises the single-channel 10-bit converter and fixed divide-by-2 clocking. Sits between the analog front-end models (`*_real` code inputs) and downstream result consumers; doubles as the formal target for conversion-latency proofs.

## Interface
- `N_BITS`, 10: resolution; width of each channel input and of the result.
- `N_CHANNELS`, 4: number of input channels; must be ≥1.
- `CLK_DIV`, 2: `clk` cycles per bit-cycle tick; must be ≥1.
- `clk` input 1: single system clock; all state on posedge.
- `reset` input 1: synchronous, active-high.
- `start_digital` input 1: request one scan round; sampled only in IDLE.
- `channel_mask_digital` input N_CHANNELS: enabled channels; latched on accepted start.
- `input_voltage_real` input N_CHANNELS*N_BITS: unsigned channel codes; channel k at bits [k*N_BITS +: N_BITS].
- `scan_digital` input 1: continuous-scan request; present only with `SAR_ADC_SCAN_EN`.
- `output_result_digital` output N_BITS: last converted code; holds until next `eoc`.
- `result_channel_digital` output CH_W: channel of `output_result_digital`. CH_W = max(1, $clog2(N_CHANNELS)).
- `eoc` output 1: one-`clk` pulse when a new result is presented.
- `last_digital` output 1: high together with `eoc` for the last enabled channel of a round.
- `busy_digital` output 1: high in every state except IDLE.

## Operation
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE:
  - On `start_digital`=1 with a nonzero mask: latch the mask, select the lowest enabled channel, clear the tick counter, go to SAMPLE.
  - A zero mask ignores `start_digital`; no `eoc` is produced.
- SAMPLE: lasts one tick.
  - On the tick, capture the selected channel code into the hold register.
  - Set the trial register to MSB-only.
  - Clear the result accumulator.
  - Go to CONVERT.
- CONVERT: one bit per tick, MSB first.
  - trial = acc | (1<<b).
  - If hold ≥ trial (unsigned), keep the bit.
  - After bit 0, go to DONE.
- DONE: lasts one `clk` cycle.
  - Registered outputs update and `eoc` pulses.
  - Then: if a higher enabled channel remains, go to its SAMPLE (tick counter cleared); else go to IDLE.
- Ideal comparator, so the result equals the held code exactly: 0 → 0, all-ones → all-ones.
- `start_digital` while busy is ignored and not queued.
- Inputs change freely outside SAMPLE ticks; only the value at the SAMPLE tick matters.

## Timing
- Tick counter runs 0..CLK_DIV-1; the tick fires in the cycle where counter = CLK_DIV-1.
- Start accepted at edge t0 → `eoc` high in the cycle after edge t0 + (N_BITS+1)*CLK_DIV + 1.
  - Example: N_BITS=10, CLK_DIV=2 → `eoc` 23 cycles after t0.
- Channel-to-channel `eoc` spacing: (N_BITS+1)*CLK_DIV + 1 cycles.
- `busy_digital` rises the cycle after acceptance. It falls the cycle after the final DONE.
- `start_digital` is accepted again in that first IDLE cycle.
- Reset values: IDLE; `eoc`, `last_digital`, `busy_digital`, `output_result_digital`, `result_channel_digital` all 0; tick counter and mask cleared.
- Reset mid-conversion aborts in the next cycle. No `eoc` is emitted for the aborted channel.

## Configuration
- `SAR_ADC_SCAN_EN` defined:
  - `scan_digital` exists.
  - In DONE of the last enabled channel with `scan_digital`=1: re-latch `channel_mask_digital` and go to SAMPLE of its lowest enabled channel, with no IDLE cycle.
  - A zero re-latched mask goes to IDLE.
  - `scan_digital`=0 ends after the current round.
- Undefined: port absent; every round ends in IDLE.

## Structure
- `sar_adc_pkg` holds:
  - state enum typedef;
  - CH_W width function;
  - lowest-set-bit / next-enabled-channel function.
- Sub-module `sar_adc_tick_gen`: parametrised divider (`CLK_DIV`) with synchronous clear; emits one-cycle `tick`.
- Formal harness binds assertions:
  - `eoc` ↔ exact latency;
  - `eoc` → result equals the held code;
  - `eoc` within bounded depth after start.

## Test plan
- N_BITS=10, CLK_DIV=2, mask=0001, ch0=0x2A5, one start → single `eoc` 23 cycles later; result 0x2A5, channel 0, `last_digital`=1.
- Mask=1010, ch1=0x000, ch3=0x3FF → `eoc` ch1 result 0x000; ch3 result 0x3FF 23 cycles later with `last_digital`=1; `busy_digital` drops next cycle.
- Mask=0000 with start pulse → `busy_digital` stays 0; no `eoc` over 100 cycles.
- Reset asserted 10 cycles into ch0 conversion → IDLE next cycle; all outputs 0; no `eoc`. A new start then completes normally.
- CLK_DIV=1, N_BITS=4, exhaustive inputs 0..15 on ch0 → every result equals input; `eoc` 6 cycles after start.
- `SAR_ADC_SCAN_EN`, mask=0011, `scan_digital`=1 for two rounds, then 0 → four `eoc` pulses spaced 23 cycles apart, then IDLE.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the multi-channel SAR ADC controller.
package sar_adc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_CONVERT,
        S_DONE
    } sar_state_t;

    // Upper bound on channel count handled by the channel-search helper.
    localparam int MAX_CH = 64;

    function automatic int ch_w(input int n_channels);
        return (n_channels > 1) ? $clog2(n_channels) : 1;
    endfunction

    // Lowest set bit of mask at index >= from; MAX_CH when none remains.
    function automatic int next_enabled(input logic [MAX_CH-1:0] mask, input int from);
        int res;
        res = MAX_CH;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                res = i;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sar_adc_tick_gen.sv
// Purpose: divides clk by CLK_DIV into a one-cycle bit-cycle tick, with synchronous clear.
// Latency: tick fires in the cycle where the counter reaches CLK_DIV-1 (CLK_DIV cycles after clear).
// Backpressure: none; free-running while clr is low.
module sar_adc_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/sar_adc_multichannel.sv
// Purpose: multi-channel SAR ADC controller; scans a latched channel mask, one eoc per channel.
// Latency: eoc (N_BITS+1)*CLK_DIV+1 cycles after start acceptance or after the previous eoc.
// Backpressure: none; start ignored while busy. SAR_ADC_SCAN_EN adds continuous scanning.
module sar_adc_multichannel
    import sar_adc_pkg::*;
#(
    parameter int  N_BITS     = 10,
    parameter int  N_CHANNELS = 4,
    parameter int  CLK_DIV    = 2,
    localparam int CH_W       = ch_w(N_CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_digital,
    input  logic [N_CHANNELS-1:0]        channel_mask_digital,
    input  logic [N_CHANNELS*N_BITS-1:0] input_voltage_real,
`ifdef SAR_ADC_SCAN_EN
    input  logic                         scan_digital,
`endif
    output logic [N_BITS-1:0]            output_result_digital,
    output logic [CH_W-1:0]              result_channel_digital,
    output logic                         eoc,
    output logic                         last_digital,
    output logic                         busy_digital
);

    sar_state_t          state;
    logic [N_CHANNELS-1:0] mask_q;
    logic [CH_W-1:0]     cur_ch;
    logic [N_BITS-1:0]   hold_q;
    logic [N_BITS-1:0]   acc_q;
    logic [N_BITS-1:0]   trial_q;

    logic                tick;
    logic                tick_clr;
    logic [N_BITS-1:0]   sel_code;
    logic [N_BITS-1:0]   cand;
    int                  first_idx;
    int                  nxt_idx;
    logic                has_next;

    // Counter restarts whenever a SAMPLE phase is about to begin.
    assign tick_clr = (state == S_IDLE) || (state == S_DONE);

    sar_adc_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign sel_code  = input_voltage_real[int'(cur_ch)*N_BITS +: N_BITS];
    assign cand      = acc_q | trial_q;
    assign first_idx = next_enabled(MAX_CH'(channel_mask_digital), 0);
    assign nxt_idx   = next_enabled(MAX_CH'(mask_q), int'(cur_ch) + 1);
    assign has_next  = (nxt_idx < N_CHANNELS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= S_IDLE;
            mask_q                 <= '0;
            cur_ch                 <= '0;
            hold_q                 <= '0;
            acc_q                  <= '0;
            trial_q                <= '0;
            output_result_digital  <= '0;
            result_channel_digital <= '0;
            eoc                    <= 1'b0;
            last_digital           <= 1'b0;
            busy_digital           <= 1'b0;
        end else begin
            eoc          <= 1'b0;
            last_digital <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_digital && (|channel_mask_digital)) begin
                        mask_q       <= channel_mask_digital;
                        cur_ch       <= CH_W'(first_idx);
                        busy_digital <= 1'b1;
                        state        <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (tick) begin
                        hold_q          <= sel_code;
                        acc_q           <= '0;
                        trial_q         <= '0;
                        trial_q[N_BITS-1] <= 1'b1;
                        state           <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    if (tick) begin
                        if (hold_q >= cand) begin
                            acc_q <= cand;
                        end
                        trial_q <= trial_q >> 1;
                        if (trial_q[0]) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    output_result_digital  <= acc_q;
                    result_channel_digital <= cur_ch;
                    eoc                    <= 1'b1;
                    if (has_next) begin
                        cur_ch <= CH_W'(nxt_idx);
                        state  <= S_SAMPLE;
                    end else begin
                        last_digital <= 1'b1;
`ifdef SAR_ADC_SCAN_EN
                        // Continuous scan: next round starts straight from DONE, no IDLE gap.
                        if (scan_digital && (|channel_mask_digital)) begin
                            mask_q <= channel_mask_digital;
                            cur_ch <= CH_W'(first_idx);
                            state  <= S_SAMPLE;
                        end else begin
                            if (scan_digital) begin
                                mask_q <= channel_mask_digital;
                            end
                            busy_digital <= 1'b0;
                            state        <= S_IDLE;
                        end
`else
                        busy_digital <= 1'b0;
                        state        <= S_IDLE;
`endif
                    end
                end
                default: begin
                    busy_digital <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_multichannel.sv
// Scoreboard bench: two DUT instances (10-bit/4ch/div2 and 4-bit/1ch/div1); expected eoc results and cycles queued at stimulus.
module tb_sar_adc_multichannel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        start_a;
    logic [3:0]  mask_a;
    logic [39:0] vin_a;
    logic [9:0]  res_a;
    logic [1:0]  ch_a;
    logic        eoc_a, last_a, busy_a;

    logic        start_b;
    logic        mask_b;
    logic [3:0]  vin_b;
    logic [3:0]  res_b;
    logic        ch_b;
    logic        eoc_b, last_b, busy_b;

`ifdef SAR_ADC_SCAN_EN
    logic        scan_a;
`endif

    sar_adc_multichannel #(.N_BITS(10), .N_CHANNELS(4), .CLK_DIV(2)) dut_a (
        .clk                    (clk),
        .reset                  (reset),
        .start_digital          (start_a),
        .channel_mask_digital   (mask_a),
        .input_voltage_real     (vin_a),
`ifdef SAR_ADC_SCAN_EN
        .scan_digital           (scan_a),
`endif
        .output_result_digital  (res_a),
        .result_channel_digital (ch_a),
        .eoc                    (eoc_a),
        .last_digital           (last_a),
        .busy_digital           (busy_a)
    );

    sar_adc_multichannel #(.N_BITS(4), .N_CHANNELS(1), .CLK_DIV(1)) dut_b (
        .clk                    (clk),
        .reset                  (reset),
        .start_digital          (start_b),
        .channel_mask_digital   (mask_b),
        .input_voltage_real     (vin_b),
`ifdef SAR_ADC_SCAN_EN
        .scan_digital           (1'b0),
`endif
        .output_result_digital  (res_b),
        .result_channel_digital (ch_b),
        .eoc                    (eoc_b),
        .last_digital           (last_b),
        .busy_digital           (busy_b)
    );

    typedef struct {
        int res;
        int ch;
        int last;
        int cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every eoc must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (eoc_a) begin
            if (qa.size() == 0) begin
                check("a_unexpected_eoc", int'(ch_a) + 1, 0);
            end else begin
                ea = qa.pop_front();
                check("a_result",  int'(res_a),  ea.res);
                check("a_channel", int'(ch_a),   ea.ch);
                check("a_last",    int'(last_a), ea.last);
                check("a_eoc_cycle", cyc,        ea.cyc);
            end
        end
        if (eoc_b) begin
            if (qb.size() == 0) begin
                check("b_unexpected_eoc", int'(res_b) + 1, 0);
            end else begin
                eb = qb.pop_front();
                check("b_result",  int'(res_b),  eb.res);
                check("b_channel", int'(ch_b),   eb.ch);
                check("b_last",    int'(last_b), eb.last);
                check("b_eoc_cycle", cyc,        eb.cyc);
            end
        end
    end

    task automatic pulse_a(input logic [3:0] m, output int c);
        mask_a  = m;
        c       = cyc;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_b(output int c);
        c       = cyc;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, qa.size() + qb.size(), 0);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_result"},  int'(res_a),  0);
        check({tag, "_channel"}, int'(ch_a),   0);
        check({tag, "_eoc"},     int'(eoc_a),  0);
        check({tag, "_last"},    int'(last_a), 0);
        check({tag, "_busy"},    int'(busy_a), 0);
    endtask

    initial begin
        int c;
        int busy_cnt;
        reset   = 1'b1;
        start_a = 1'b0;
        mask_a  = '0;
        vin_a   = '0;
        start_b = 1'b0;
        mask_b  = 1'b1;
        vin_b   = '0;
`ifdef SAR_ADC_SCAN_EN
        scan_a  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_a_zero("reset");
        check("reset_b_busy", int'(busy_b), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single channel; input changes before and after the SAMPLE tick.
        vin_a[9:0] = 10'h111;
        pulse_a(4'b0001, c);
        qa.push_back('{32'h2A5, 0, 1, c + 24});
        check("t1_busy_rise", int'(busy_a), 1);
        vin_a[9:0] = 10'h2A5;
        repeat (4) @(negedge clk);
        vin_a[9:0] = 10'h0F0;
        drain("t1_timeout", 60);
        check("t1_busy_fall", int'(busy_a), 0);

        // Two channels: zero and full-scale codes.
        vin_a = {10'h3FF, 10'h0AA, 10'h000, 10'h123};
        pulse_a(4'b1010, c);
        qa.push_back('{0,      1, 0, c + 24});
        qa.push_back('{32'h3FF, 3, 1, c + 47});
        drain("t2_timeout", 80);
        check("t2_busy_fall", int'(busy_a), 0);

        // Zero mask: start ignored.
        pulse_a(4'b0000, c);
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy_a) busy_cnt++;
            @(negedge clk);
        end
        check("t3_busy_cycles", busy_cnt, 0);

        // Reset 10 cycles into a conversion aborts it.
        vin_a[9:0] = 10'h155;
        pulse_a(4'b0001, c);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_a_zero("t4_abort");
        repeat (40) @(negedge clk);
        pulse_a(4'b0001, c);
        qa.push_back('{32'h155, 0, 1, c + 24});
        drain("t4_timeout", 60);

        // Small instance: exhaustive 4-bit codes, 6-cycle latency.
        for (int v = 0; v < 16; v++) begin
            vin_b = 4'(v);
            pulse_b(c);
            qb.push_back('{v, 0, 1, c + 7});
            drain("t5_timeout", 20);
        end

`ifdef SAR_ADC_SCAN_EN
        // Continuous scan for two rounds, then stop.
        vin_a  = {10'h000, 10'h000, 10'h01F, 10'h3C3};
        scan_a = 1'b1;
        pulse_a(4'b0011, c);
        qa.push_back('{32'h3C3, 0, 0, c + 24});
        qa.push_back('{32'h01F, 1, 1, c + 47});
        qa.push_back('{32'h3C3, 0, 0, c + 70});
        qa.push_back('{32'h01F, 1, 1, c + 93});
        for (int n = 0; n < 120 && qa.size() > 1; n++) @(negedge clk);
        scan_a = 1'b0;
        drain("t6_timeout", 60);
        check("t6_busy_fall", int'(busy_a), 0);
        repeat (40) @(negedge clk);
        check("t6_idle_busy", int'(busy_a), 0);
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
